// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame constants and receiver state encoding shared with the transmitter
package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 8;
   localparam int DEFAULT_DATA_BITS    = 8;

   localparam logic startBit = 1'b0;
   localparam logic stopBit  = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// rtl/rx_sync.sv - two-flop line synchronizer with registered falling-edge detect
module rx_sync (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_async,
   output logic o_sync,
   output logic o_fall
);

   logic meta;
   logic sync;
   logic prev;

   // Preset high so a released reset never looks like a start edge on an idle line.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         meta <= 1'b1;
         sync <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= i_async;
         sync <= meta;
         prev <= sync;
      end
   end

   assign o_sync = sync;
   assign o_fall = prev & ~sync;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receive FSM: start/data/parity/stop recovery and byte strobe
import uart_pkg::*;

module uart_receiver #(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_BITS    = DEFAULT_DATA_BITS,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_rxdata,
   output logic [DATA_BITS-1:0] o_dataout,
   output logic                 o_rxdone,
   output logic                 o_parityerr,
   output logic                 o_frameerr,
   output logic                 o_busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic          ODD      = (PARITY_ODD != 0);

   rx_state_t state;
   rx_state_t next_state;

   logic                 sync;
   logic                 fall;
   logic                 tick;
   logic [CW-1:0]        sample_cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 parity_err;

   rx_sync u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_async (i_rxdata),
      .o_sync  (sync),
      .o_fall  (fall)
   );

   // Start bit is checked mid-bit; every later sample lands one full bit period after the previous.
   always_comb begin
      tick = 1'b0;
      if (state == S_START) tick = (sample_cnt == HALF);
      else                  tick = (sample_cnt == LAST_CNT);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) state <= S_IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         S_IDLE:   if (fall) next_state = S_START;
         S_START:  if (tick) next_state = (sync == startBit) ? S_DATA : S_IDLE;
         S_DATA:   if (tick && bit_cnt == LAST_BIT) next_state = S_PARITY;
         S_PARITY: if (tick) next_state = S_STOP;
         S_STOP:   if (tick) next_state = (sync == stopBit) ? S_IDLE : S_BREAK;
         S_BREAK:  if (sync) next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state != S_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sample_cnt  <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         parity_err  <= 1'b0;
         o_dataout   <= '0;
         o_rxdone    <= 1'b0;
         o_parityerr <= 1'b0;
         o_frameerr  <= 1'b0;
      end else begin
         o_rxdone <= 1'b0;

         // The edge cycle itself counts as sample 0, so the counter starts at 1 on leaving IDLE.
         if (state == S_IDLE)  sample_cnt <= fall ? CW'(1) : '0;
         else if (tick)        sample_cnt <= '0;
         else                  sample_cnt <= sample_cnt + 1'b1;

         if (state == S_IDLE || (state == S_START && tick)) begin
            bit_cnt <= '0;
         end else if (state == S_DATA && tick) begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= {sync, shift[DATA_BITS-1:1]};
         end

         if (state == S_PARITY && tick) parity_err <= sync ^ (^shift) ^ ODD;

         if (state == S_STOP && tick) begin
            o_dataout   <= shift;
            o_parityerr <= parity_err;
            o_frameerr  <= (sync != stopBit);
            o_rxdone    <= 1'b1;
         end
      end
   end

endmodule
